// File: rtl/debounced_gate_bank.sv
// Debounced N-input logic gate with a button-selected gate function.
// Each raw input and the mode button gets a 2-flop synchroniser and a stable-count debouncer.

module debounced_gate_bank_lane #(
  parameter int DEBOUNCE_CYCLES_P = 120000,
  parameter int CNT_W             = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES_P - 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign sync   = sync_q[1];
  assign accept = (sync != clean) && (cnt == CNT_LAST);
  // Rise is exposed combinationally so a consumer can act on the same edge the clean bit flips.
  assign rise   = accept & sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      clean  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync == clean) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module debounced_gate_bank #(
  parameter int NUM_IN_P          = 2,
  parameter int DEBOUNCE_CYCLES_P = 120000
) (
  input  logic                clk_12mhz_i,
  input  logic                reset_n_async_unsafe_i,
  input  logic [NUM_IN_P-1:0] in_async_unsafe_i,
  input  logic                mode_btn_async_unsafe_i,
  output logic                result_o,
  output logic [2:0]          mode_o,
  output logic                change_o,
  output logic [NUM_IN_P-1:0] in_clean_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES_P + 1);

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  logic btn_rise;
  logic unused_btn_clean;
  logic gate_val;

  for (genvar i = 0; i < NUM_IN_P; i++) begin : g_in
    logic unused_rise;
    debounced_gate_bank_lane #(
      .DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P),
      .CNT_W            (CNT_W)
    ) u_lane (
      .clk  (clk_12mhz_i),
      .rst_n(reset_n_async_unsafe_i),
      .raw  (in_async_unsafe_i[i]),
      .clean(in_clean_o[i]),
      .rise (unused_rise)
    );
  end

  debounced_gate_bank_lane #(
    .DEBOUNCE_CYCLES_P(DEBOUNCE_CYCLES_P),
    .CNT_W            (CNT_W)
  ) u_btn (
    .clk  (clk_12mhz_i),
    .rst_n(reset_n_async_unsafe_i),
    .raw  (mode_btn_async_unsafe_i),
    .clean(unused_btn_clean),
    .rise (btn_rise)
  );

  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      mode_o <= MODE_AND;
    end else if (btn_rise) begin
      mode_o <= (mode_o == MODE_XNOR) ? MODE_AND : mode_o + 3'd1;
    end
  end

  always_comb begin
    gate_val = 1'b0;
    case (mode_o)
      MODE_AND:  gate_val = &in_clean_o;
      MODE_OR:   gate_val = |in_clean_o;
      MODE_NAND: gate_val = ~&in_clean_o;
      MODE_NOR:  gate_val = ~|in_clean_o;
      MODE_XOR:  gate_val = ^in_clean_o;
      MODE_XNOR: gate_val = ~^in_clean_o;
      default:   gate_val = 1'b0;
    endcase
  end

  // change_o is registered alongside result_o so both move on the same edge.
  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      result_o <= 1'b0;
      change_o <= 1'b0;
    end else begin
      result_o <= gate_val;
      change_o <= gate_val ^ result_o;
    end
  end
endmodule
